uart_frame_ctrl: RTL and testbench

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

---
 rtl/uart_frame_pkg.sv | 28 ++
 rtl/frame_fifo.sv | 66 ++++++
 rtl/uart_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller: FSM states,
// frame error codes and the default start-of-frame marker.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_PARITY   = 3'd1,
        ERR_CHECKSUM = 3'd2,
        ERR_LENGTH   = 3'd3,
        ERR_OVERFLOW = 3'd4,
        ERR_TIMEOUT  = 3'd5
    } err_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic lenInRange(input logic [7:0] len, input int maxLen);
        return (len != 8'd0) && (int'(len) <= maxLen);
    endfunction

endpackage

// File: rtl/frame_fifo.sv
// Show-ahead byte FIFO with a tentative write pointer: writes stay invisible
// to the reader until commit_i, and rollback_i discards them.
module frame_fifo #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          wrEn_i,
    input  logic [7:0]    wrData_i,
    input  logic          commit_i,
    input  logic          rollback_i,
    input  logic          ready_i,
    output logic [7:0]    data_o,
    output logic          valid_o,
    output logic [AW:0]   free_o
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] rdPtr_q, cmtPtr_q, wrPtr_q;
    logic [AW:0] rdPtr_d, cmtPtr_d, wrPtr_d;
    logic [AW:0] count;

    // Pointers carry one extra bit so a completely full FIFO is distinguishable from empty.
    assign count   = cmtPtr_q - rdPtr_q;
    assign valid_o = (count != '0);
    assign free_o  = FULL - count;
    assign data_o  = valid_o ? mem_q[rdPtr_q[AW-1:0]] : 8'd0;

    always_comb begin
        rdPtr_d  = rdPtr_q;
        cmtPtr_d = cmtPtr_q;
        wrPtr_d  = wrPtr_q;
        if (valid_o && ready_i) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (rollback_i) begin
            wrPtr_d = cmtPtr_q;
        end else if (commit_i) begin
            cmtPtr_d = wrPtr_q;
        end else if (wrEn_i) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rdPtr_q  <= '0;
            cmtPtr_q <= '0;
            wrPtr_q  <= '0;
        end else begin
            rdPtr_q  <= rdPtr_d;
            cmtPtr_q <= cmtPtr_d;
            wrPtr_q  <= wrPtr_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (wrEn_i) begin
            mem_q[wrPtr_q[AW-1:0]] <= wrData_i;
        end
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses SYNC/LEN/payload/CHK frames from a UART byte stream into a FIFO.
// Define UART_FRAME_TIMEOUT_EN to abort stalled frames after TIMEOUT_CLKS idle clocks.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN      = 16,
    parameter int         FIFO_DEPTH   = 32,
    parameter int         TIMEOUT_CLKS = 10000
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    input  logic       i_Rx_Error,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    input  logic       i_Ready,
    output logic       o_Frame_Done,
    output logic       o_Frame_Err,
    output logic [2:0] o_Err_Code,
    output logic       o_Busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_badMaxLen
        $error("uart_frame_ctrl: MAX_LEN must be 1..255");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < MAX_LEN) begin : g_badDepth
        $error("uart_frame_ctrl: FIFO_DEPTH must be a power of two >= MAX_LEN");
    end
    if (TIMEOUT_CLKS < 1) begin : g_badTimeout
        $error("uart_frame_ctrl: TIMEOUT_CLKS must be positive");
    end

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  sum_q;
    logic        done_q;
    logic        err_q;
    err_t        code_q;

    logic        dvGood, dvBad, lenBad, noRoom, timeoutHit;
    logic        wrEn, commit, rollback;
    logic [7:0]  sumNext;
    logic [AW:0] fifoFree;

    always_comb begin
        dvGood   = i_Rx_DV && !i_Rx_Error;
        dvBad    = i_Rx_DV && i_Rx_Error;
        sumNext  = sum_q + i_Rx_Byte;
        lenBad   = !lenInRange(i_Rx_Byte, MAX_LEN);
        noRoom   = 16'(fifoFree) < {8'd0, i_Rx_Byte};
        wrEn     = (state_q == ST_PAYLOAD) && dvGood;
        commit   = (state_q == ST_CHECK) && dvGood && (sumNext == 8'd0);
        rollback = ((state_q == ST_PAYLOAD || state_q == ST_CHECK) && (dvBad || timeoutHit))
                 || ((state_q == ST_CHECK) && dvGood && (sumNext != 8'd0));
    end

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    logic [TW-1:0] idleClks_q;

    assign timeoutHit = (state_q != ST_IDLE) && !i_Rx_DV
                     && (idleClks_q == TW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge i_Clock) begin
        if (i_Reset || state_q == ST_IDLE || i_Rx_DV || timeoutHit) begin
            idleClks_q <= '0;
        end else begin
            idleClks_q <= idleClks_q + 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    // The running sum is seeded with LEN so CHECK only has to add the CHK byte.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            sum_q   <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
            if (timeoutHit) begin
                state_q <= ST_IDLE;
                if (state_q != ST_SKIP) begin
                    err_q  <= 1'b1;
                    code_q <= ERR_TIMEOUT;
                end
            end else if (i_Rx_DV) begin
                case (state_q)
                    ST_IDLE: begin
                        if (dvGood && i_Rx_Byte == SYNC_BYTE) begin
                            state_q <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (i_Rx_Error) begin
                            err_q   <= 1'b1;
                            code_q  <= ERR_PARITY;
                            state_q <= ST_IDLE;
                        end else if (lenBad) begin
                            err_q   <= 1'b1;
                            code_q  <= ERR_LENGTH;
                            state_q <= ST_IDLE;
                        end else if (noRoom) begin
                            err_q   <= 1'b1;
                            code_q  <= ERR_OVERFLOW;
                            cnt_q   <= i_Rx_Byte;
                            state_q <= ST_SKIP;
                        end else begin
                            cnt_q   <= i_Rx_Byte;
                            sum_q   <= i_Rx_Byte;
                            state_q <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (i_Rx_Error) begin
                            err_q   <= 1'b1;
                            code_q  <= ERR_PARITY;
                            state_q <= ST_IDLE;
                        end else begin
                            sum_q <= sumNext;
                            cnt_q <= cnt_q - 8'd1;
                            if (cnt_q == 8'd1) begin
                                state_q <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        state_q <= ST_IDLE;
                        if (i_Rx_Error) begin
                            err_q  <= 1'b1;
                            code_q <= ERR_PARITY;
                        end else if (sumNext == 8'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                            code_q <= ERR_CHECKSUM;
                        end
                    end
                    ST_SKIP: begin
                        // cnt_q was loaded with LEN, so LEN+1 bytes drain before IDLE.
                        if (cnt_q == 8'd0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_Frame_Done = done_q;
    assign o_Frame_Err  = err_q;
    assign o_Err_Code   = code_q;
    assign o_Busy       = (state_q != ST_IDLE);

    frame_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) fifo (
        .clock_i    (i_Clock),
        .reset_i    (i_Reset),
        .wrEn_i     (wrEn),
        .wrData_i   (i_Rx_Byte),
        .commit_i   (commit),
        .rollback_i (rollback),
        .ready_i    (i_Ready),
        .data_o     (o_Data),
        .valid_o    (o_Valid),
        .free_o     (fifoFree)
    );

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: frame-level reference model plus
// directed scenarios; honours UART_FRAME_TIMEOUT_EN when defined.
module tb_uart_frame_ctrl;

    localparam logic [7:0] SYNC  = 8'hA5;
    localparam int         MAXL  = 16;
    localparam int         DEPTH = 32;
    localparam int         TMO   = 10000;

    localparam int M_IDLE = 0;
    localparam int M_LEN  = 1;
    localparam int M_PAY  = 2;
    localparam int M_CHK  = 3;
    localparam int M_SKIP = 4;

    typedef logic [7:0] bq_t[$];

    logic       i_Clock    = 1'b0;
    logic       i_Reset    = 1'b1;
    logic       i_Rx_DV    = 1'b0;
    logic [7:0] i_Rx_Byte  = 8'd0;
    logic       i_Rx_Error = 1'b0;
    logic       i_Ready    = 1'b0;
    logic [7:0] o_Data;
    logic       o_Valid;
    logic       o_Frame_Done;
    logic       o_Frame_Err;
    logic [2:0] o_Err_Code;
    logic       o_Busy;

    uart_frame_ctrl #(
        .SYNC_BYTE    (SYNC),
        .MAX_LEN      (MAXL),
        .FIFO_DEPTH   (DEPTH),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_Rx_DV      (i_Rx_DV),
        .i_Rx_Byte    (i_Rx_Byte),
        .i_Rx_Error   (i_Rx_Error),
        .o_Data       (o_Data),
        .o_Valid      (o_Valid),
        .i_Ready      (i_Ready),
        .o_Frame_Done (o_Frame_Done),
        .o_Frame_Err  (o_Frame_Err),
        .o_Err_Code   (o_Err_Code),
        .o_Busy       (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    int tests = 0;
    int fails = 0;

    // Reference model: committed byte queue, tentative frame bytes, parser position.
    bq_t        cq;
    bq_t        pend;
    int         mode;
    int         frameLen;
    int         skipLeft;
    int         idleClks;
    logic       expValid, expDone, expErr, expBusy;
    logic [7:0] expData;
    logic [2:0] expCode;

    int         doneSeen;
    int         errSeen;
    logic [2:0] lastCode;
    bit         validSeen;
    bq_t        popped;

    int         rdyMode = 1;
    int         gapMax  = 0;
    logic       rstIn   = 1'b1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        cq.delete();
        pend.delete();
        mode     = M_IDLE;
        frameLen = 0;
        skipLeft = 0;
        idleClks = 0;
        expValid = 1'b0;
        expData  = 8'd0;
        expDone  = 1'b0;
        expErr   = 1'b0;
        expCode  = 3'd0;
        expBusy  = 1'b0;
    endtask

    task automatic flagErr(input logic [2:0] code);
        expErr  = 1'b1;
        expCode = code;
    endtask

    task automatic modelStep(input logic dv, input logic [7:0] b, input logic er, input logic rdy);
        bit popNow;
        bit commitNow;
        bit tmo;
        int freeNow;
        int s;
        popNow    = (cq.size() != 0) && rdy;
        commitNow = 0;
        tmo       = 0;
        freeNow   = DEPTH - cq.size();
        expDone   = 1'b0;
        expErr    = 1'b0;
        expCode   = 3'd0;
`ifdef UART_FRAME_TIMEOUT_EN
        if (mode != M_IDLE) begin
            if (dv) idleClks = 0;
            else begin
                idleClks++;
                if (idleClks == TMO) tmo = 1;
            end
        end else begin
            idleClks = 0;
        end
`endif
        if (tmo) begin
            if (mode != M_SKIP) flagErr(3'd5);
            pend.delete();
            mode     = M_IDLE;
            idleClks = 0;
        end else if (dv) begin
            case (mode)
                M_IDLE: if (!er && b == SYNC) mode = M_LEN;
                M_LEN: begin
                    if (er) begin
                        flagErr(3'd1);
                        mode = M_IDLE;
                    end else if (b == 8'd0 || int'(b) > MAXL) begin
                        flagErr(3'd3);
                        mode = M_IDLE;
                    end else if (freeNow < int'(b)) begin
                        flagErr(3'd4);
                        skipLeft = int'(b) + 1;
                        mode     = M_SKIP;
                    end else begin
                        frameLen = int'(b);
                        pend.delete();
                        mode = M_PAY;
                    end
                end
                M_PAY: begin
                    if (er) begin
                        flagErr(3'd1);
                        pend.delete();
                        mode = M_IDLE;
                    end else begin
                        pend.push_back(b);
                        if (pend.size() == frameLen) mode = M_CHK;
                    end
                end
                M_CHK: begin
                    if (er) begin
                        flagErr(3'd1);
                    end else begin
                        s = frameLen + int'(b);
                        foreach (pend[i]) s += int'(pend[i]);
                        if (s % 256 == 0) begin
                            expDone   = 1'b1;
                            commitNow = 1;
                        end else begin
                            flagErr(3'd2);
                        end
                    end
                    mode = M_IDLE;
                end
                default: begin
                    skipLeft--;
                    if (skipLeft == 0) mode = M_IDLE;
                end
            endcase
        end
        if (popNow) void'(cq.pop_front());
        if (commitNow) foreach (pend[i]) cq.push_back(pend[i]);
        if (commitNow || mode == M_IDLE) pend.delete();
        expValid = (cq.size() != 0);
        expData  = expValid ? cq[0] : 8'd0;
        expBusy  = (mode != M_IDLE);
    endtask

    task automatic checkOutput();
        cmp("o_Valid", o_Valid, expValid);
        cmp("o_Data", o_Data, expData);
        cmp("o_Frame_Done", o_Frame_Done, expDone);
        cmp("o_Frame_Err", o_Frame_Err, expErr);
        cmp("o_Err_Code", o_Err_Code, expCode);
        cmp("o_Busy", o_Busy, expBusy);
        if (o_Frame_Done === 1'b1) doneSeen++;
        if (o_Frame_Err === 1'b1) begin
            errSeen++;
            lastCode = o_Err_Code;
        end
        if (o_Valid === 1'b1) validSeen = 1;
    endtask

    task automatic applyStimulus(input logic dv, input logic [7:0] b, input logic er, input logic rdy);
        i_Reset    = rstIn;
        i_Rx_DV    = dv;
        i_Rx_Byte  = b;
        i_Rx_Error = er;
        i_Ready    = rdy;
        if (rstIn) modelReset();
        else modelStep(dv, b, er, rdy);
    endtask

    task automatic tick(input logic dv, input logic [7:0] b, input logic er);
        logic rdy;
        checkOutput();
        case (rdyMode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        if (o_Valid === 1'b1 && rdy) popped.push_back(o_Data);
        applyStimulus(dv, b, er, rdy);
        @(negedge i_Clock);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic sendByte(input logic [7:0] b, input logic er);
        tick(1'b1, b, er);
        if (gapMax > 0) idle($urandom_range(0, gapMax));
    endtask

    task automatic sendFrame(input bq_t pl, input bit badChk, input int parIdx);
        bq_t        f;
        logic [7:0] s;
        logic [7:0] chk;
        f.push_back(SYNC);
        f.push_back(8'(pl.size()));
        s = 8'(pl.size());
        foreach (pl[i]) begin
            f.push_back(pl[i]);
            s = s + pl[i];
        end
        chk = 8'd0 - s;
        if (badChk) chk = chk + 8'd1;
        f.push_back(chk);
        foreach (f[i]) sendByte(f[i], 1'(i == parIdx));
    endtask

    task automatic clearObs();
        doneSeen  = 0;
        errSeen   = 0;
        lastCode  = 3'd0;
        validSeen = 0;
        popped.delete();
    endtask

    initial begin
        bq_t pl;
        int  k;
        int  len;
        modelReset();
        clearObs();
        @(posedge i_Clock);
        @(negedge i_Clock);
        rstIn = 1'b1;
        idle(2);
        cmp("reset_valid", o_Valid, 0);
        cmp("reset_busy", o_Busy, 0);
        cmp("reset_data", o_Data, 0);
        rstIn = 1'b0;
        idle(3);

        // Good frame: done next cycle after CHK, data visible at the same time.
        rdyMode = 0;
        gapMax  = 0;
        clearObs();
        pl = {8'h11, 8'h22, 8'h33};
        sendFrame(pl, 0, -1);
        cmp("t033_done_pulse", o_Frame_Done, 1);
        cmp("t033_first_valid", o_Valid, 1);
        cmp("t033_first_data", o_Data, 8'h11);
        idle(2);
        cmp("t033_done_count", doneSeen, 1);
        rdyMode = 1;
        idle(6);
        cmp("t033_pop_count", popped.size(), 3);
        if (popped.size() == 3) begin
            cmp("t033_byte0", popped[0], 8'h11);
            cmp("t033_byte1", popped[1], 8'h22);
            cmp("t033_byte2", popped[2], 8'h33);
        end

        // Bad checksum.
        clearObs();
        gapMax = 1;
        sendFrame(pl, 1, -1);
        idle(3);
        cmp("t034_err_count", errSeen, 1);
        cmp("t034_code", lastCode, 2);
        cmp("t034_valid_seen", validSeen, 0);
        cmp("t034_done_count", doneSeen, 0);

        // Parity on second payload byte, then a clean frame.
        clearObs();
        pl = {8'h44, 8'h55, 8'h66};
        sendFrame(pl, 0, 3);
        idle(2);
        cmp("t035_err_count", errSeen, 1);
        cmp("t035_code", lastCode, 1);
        cmp("t035_valid_seen", validSeen, 0);
        pl = {8'h01, 8'h02};
        sendFrame(pl, 0, -1);
        idle(4);
        cmp("t035_done_count", doneSeen, 1);
        cmp("t035_pop_count", popped.size(), 2);
        if (popped.size() == 2) begin
            cmp("t035_byte0", popped[0], 8'h01);
            cmp("t035_byte1", popped[1], 8'h02);
        end

        // Illegal lengths.
        clearObs();
        sendByte(SYNC, 0);
        sendByte(8'h00, 0);
        idle(2);
        cmp("t036_len0_code", lastCode, 3);
        cmp("t036_len0_busy", o_Busy, 0);
        sendByte(SYNC, 0);
        sendByte(8'h11, 0);
        idle(2);
        cmp("t036_err_count", errSeen, 2);
        cmp("t036_len17_code", lastCode, 3);
        cmp("t036_len17_busy", o_Busy, 0);

        // Overflow: two full frames fill the FIFO, the third is skipped.
        idle(4);
        rdyMode = 0;
        clearObs();
        for (int f = 0; f < 3; f++) begin
            pl.delete();
            for (int i = 0; i < 16; i++) pl.push_back(8'(f * 64 + i + 1));
            sendFrame(pl, 0, -1);
        end
        idle(2);
        cmp("t037_done_count", doneSeen, 2);
        cmp("t037_err_count", errSeen, 1);
        cmp("t037_code", lastCode, 4);
        cmp("t037_busy", o_Busy, 0);
        rdyMode = 1;
        idle(40);
        cmp("t037_pop_count", popped.size(), 32);
        if (popped.size() == 32) begin
            cmp("t037_byte0", popped[0], 8'h01);
            cmp("t037_byte16", popped[16], 8'h41);
            cmp("t037_byte31", popped[31], 8'h50);
        end
        clearObs();
        pl = {8'h07, 8'h08, 8'h09};
        sendFrame(pl, 0, -1);
        idle(5);
        cmp("t037_fourth_done", doneSeen, 1);
        cmp("t037_fourth_pops", popped.size(), 3);

        // Stall after two payload bytes.
        clearObs();
        gapMax = 0;
        sendByte(SYNC, 0);
        sendByte(8'h03, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        idle(TMO);
        sendByte(8'h33, 0);
        sendByte(8'h97, 0);
        idle(3);
`ifdef UART_FRAME_TIMEOUT_EN
        cmp("t038_err_count", errSeen, 1);
        cmp("t038_code", lastCode, 5);
        cmp("t038_done_count", doneSeen, 0);
`else
        cmp("t038_err_count", errSeen, 0);
        cmp("t038_done_count", doneSeen, 1);
        cmp("t038_pop_count", popped.size(), 3);
`endif

        // Randomized traffic against the reference model.
        rdyMode = 2;
        gapMax  = 2;
        repeat (250) begin
            k   = $urandom_range(0, 9);
            len = $urandom_range(1, MAXL);
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            case (k)
                0, 1, 2, 3: sendFrame(pl, 0, -1);
                4:          sendFrame(pl, 1, -1);
                5:          sendFrame(pl, 0, $urandom_range(0, len + 2));
                6: begin
                    sendByte(SYNC, 0);
                    if ($urandom_range(0, 1) != 0) sendByte(8'h00, 0);
                    else sendByte(8'($urandom_range(MAXL + 1, 255)), 0);
                end
                7:          sendByte(8'($urandom), 1'($urandom));
                8: begin
                    sendByte(SYNC, 0);
                    sendByte(8'(len), 0);
                    sendByte(8'($urandom), 0);
                    rstIn = 1'b1;
                    tick(1'b0, 8'd0, 1'b0);
                    rstIn = 1'b0;
                end
                default: begin
                    rdyMode = 0;
                    sendFrame(pl, 0, -1);
                    rdyMode = 2;
                end
            endcase
        end
        rdyMode = 1;
        idle(40);
        cmp("final_drained", o_Valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
